uart_block_assembler: RTL

UART_BLOCK_ASSEMBLER -- requirements
Module: uart_block_assembler

---
 rtl/uart_block_assembler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_block_assembler.sv
// Collects a 32-byte UART frame into a 128-bit plaintext block and a 128-bit key,
// then holds both for the AES core until it handshakes; partial frames expire after an idle timeout.
module uart_block_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 173600
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] blk_data,
    output logic [127:0] blk_key,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [4:0]   byte_cnt,
    output logic         overrun,
    output logic         timeout_err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_DATA,
        S_KEY,
        S_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          byte_cnt_q, byte_cnt_d;
    logic [127:0]        data_q, data_d;
    logic [127:0]        key_q, key_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                overrun_q, overrun_d;
    logic                timeout_err_q, timeout_err_d;

    logic                handshake;
    logic                accept;
    logic                counting;
    logic                timeout;
    logic [4:0]          pos;
    logic [3:0]          lane;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_DATA;
            byte_cnt_q    <= '0;
            data_q        <= '0;
            key_q         <= '0;
            idle_q        <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            data_q        <= data_d;
            key_q         <= key_d;
            idle_q        <= idle_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // A timeout or a handshake restarts the frame, so a coincident byte lands at position 0.
    always_comb begin
        handshake = (state_q == S_HOLD) && blk_ready;
        accept    = rx_valid && ((state_q != S_HOLD) || blk_ready);
        counting  = (state_q != S_HOLD) && (byte_cnt_q != 5'd0);
        timeout   = counting && (idle_q >= IDLE_LAST);
        pos       = (timeout || handshake) ? 5'd0 : byte_cnt_q;
        lane      = 4'd15 - pos[3:0];

        data_d     = data_q;
        key_d      = key_q;
        byte_cnt_d = byte_cnt_q;
        if (accept) begin
            if (!pos[4]) begin
                data_d[{lane, 3'b000} +: 8] = rx_data;
            end else begin
                key_d[{lane, 3'b000} +: 8] = rx_data;
            end
            byte_cnt_d = pos + 5'd1;
        end else if (timeout) begin
            byte_cnt_d = '0;
        end

        idle_d = idle_q;
        if (accept || timeout || !counting) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        overrun_d     = rx_valid && (state_q == S_HOLD) && !blk_ready;
        timeout_err_d = timeout;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_DATA: begin
                if (!timeout && accept && (byte_cnt_q == 5'd15)) begin
                    state_d = S_KEY;
                end
            end
            S_KEY: begin
                if (timeout) begin
                    state_d = S_DATA;
                end else if (accept && (byte_cnt_q == 5'd31)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (blk_ready) begin
                    state_d = S_DATA;
                end
            end
            default: state_d = S_DATA;
        endcase
    end

    always_comb begin
        blk_valid   = (state_q == S_HOLD);
        blk_data    = data_q;
        blk_key     = key_q;
        byte_cnt    = byte_cnt_q;
        overrun     = overrun_q;
        timeout_err = timeout_err_q;
    end

endmodule
